instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  IF stage plus IF/ID pipeline register of the 5-stage MIPS pipeline. Holds the PC, issues
//  requests to a variable-latency instruction memory, and delivers instruction/PC+4 to ID.
//  Takes the taken-branch flag Z and the jump/jr redirects resolved in ID. Also takes the
//  load-use stall from the hazard unit. No branch delay slot: a redirect flushes IF/ID.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  NOP_INSTR 32'h0000_0000  word injected into IF/ID on flush/bubble (sll $0,$0,0)
// PORTS
//  clk             in   1   rising-edge clock
//  reset           in   1   asynchronous, active-high reset
//  Stall           in   1   hold PC and IF/ID (load-use hazard)
//  Z               in   1   branch taken, from ID zero detector
//  BranchAddr      in   32  branch target from ID
//  J               in   1   j/jal in ID
//  JumpAddr        in   32  jump target from ID
//  JR              in   1   jr/jalr in ID
//  JrAddr          in   32  forwarded Rs value from ID
//  Imem_Req        out  1   instruction read request
//  Imem_Addr       out  32  word address; stable while Imem_Req=1 and Imem_Ready=0
//  Imem_Ready      in   1   Imem_Instr valid this cycle; completes the request
//  Imem_Instr      in   32  fetched word
//  Instruction_id  out  32  IF/ID instruction
//  PC_id           out  32  IF/ID PC+4
//  Valid_id        out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (async): PC=RESET_PC, state=FETCH, kill=0, skid empty; Instruction_id=NOP_INSTR,
//   PC_id=0, Valid_id=0; Imem_Req=0 while reset is high, 1 from the first clk edge after.
//  Redirect = ~Stall & (Z|JR|J). Priority Z > JR > J; target = BranchAddr/JrAddr/JumpAddr.
//   Redirect while Stall=1 is ignored (hazard unit re-presents it once operands are ready).
//  Redirect cycle: PC<=target, IF/ID<=NOP_INSTR/Valid_id=0 at the next edge. If a request is
//   outstanding and not completing this cycle, go to KILL. A word returned in the redirect
//   cycle is discarded.
//  FSM (Imem_Req=1 in FETCH and KILL):
//   FETCH: Imem_Addr=PC. On Imem_Ready & ~Stall & ~redirect: IF/ID<={Imem_Instr,PC+4,1},
//    PC<=PC+4. On Imem_Ready & Stall: word->skid, PC<=PC+4, go HOLD.
//    No Ready: IF/ID gets a bubble (Valid_id=0) unless Stall (then IF/ID holds).
//   HOLD: Imem_Req=0. When ~Stall: IF/ID<=skid, go FETCH. A redirect in the release cycle
//    drops the skid and flushes IF/ID.
//   KILL: Imem_Addr=old PC (kept stable); on Imem_Ready drop the word and go FETCH. The new PC
//    is already loaded. A further redirect in KILL only updates PC.
//  Throughput: Ready in the same cycle as Req gives one instruction per cycle; latency from
//   Imem_Ready to Instruction_id is 1 cycle.
//  Stall=1 with no completion: PC, IF/ID and state are unchanged.
//  Arithmetic: PC+4 is a 32-bit modulo add; 32'hFFFF_FFFC+4 wraps to 0. Targets are used
//   unmodified; low two bits are not checked.
//  Reset mid-request: outstanding request abandoned, no kill bookkeeping kept. The memory
//   must accept the new request.
// STRUCTURE
//  Shared package (mips_pkg): fetch state encodings FETCH/HOLD/KILL, NOP_INSTR,
//   RESET_PC default.
//  Sub-module pc_select: combinational priority mux (Z,JR,J,targets,PC+4) -> next PC.
//  Top holds PC reg, FSM, skid register and IF/ID register.
// TESTING
//  1 Reset, Imem_Ready tied 1 -> Imem_Addr 0,4,8,... one per cycle; Valid_id=0 first cycle, then
//    PC_id=4,8,...
//  2 Instruction at PC 0x10 in ID, Z=1, BranchAddr=0x40 -> next Imem_Addr=0x40; Instruction_id
//    =NOP, Valid_id=0 for one cycle; then the word at 0x40 with PC_id=0x44.
//  3 Ready 3 cycles after Req at 0x20; J=1 with JumpAddr=0x80 in cycle 1 -> addr 0x20 held
//    until Ready, its word dropped, then the 0x80 request issues; no 0x20 word reaches ID.
//  4 Stall=1 for 2 cycles while Ready returns word of 0x8 -> IF/ID frozen, Imem_Req=0 in
//    HOLD; on release Instruction_id=word(0x8), PC_id=0xC, then fetch continues at 0xC.
//  5 Z=1, JR=1, J=1 with distinct targets -> BranchAddr taken. Same with Stall=1 ->
//    no redirect, PC unchanged.
//  6 PC=0xFFFF_FFFC, Ready=1 -> PC_id=0, next Imem_Addr=0. Reset asserted mid-wait ->
//    outputs reset immediately, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: fetch FSM encoding and reset/bubble constants.
package mips_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_KILL  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000; // sll $0,$0,0

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/response bus between the fetch stage and the memory.
interface instruction_fetch_if;

    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Ready;
    logic [31:0] Imem_Instr;

    modport master (output Imem_Req, output Imem_Addr, input Imem_Ready, input Imem_Instr);
    modport slave  (input Imem_Req, input Imem_Addr, output Imem_Ready, output Imem_Instr);

endinterface

// File: rtl/instruction_fetch_pc_select.sv
// Next-PC priority mux: branch beats jr beats jump; otherwise sequential PC+4.
module pc_select (
    input  logic        stall_i,
    input  logic        z_i,
    input  logic        jr_i,
    input  logic        j_i,
    input  logic [31:0] branch_addr_i,
    input  logic [31:0] jr_addr_i,
    input  logic [31:0] jump_addr_i,
    input  logic [31:0] pc_i,
    output logic        redirect_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] next_pc_o
);

    assign pc_plus4_o = pc_i + 32'd4;
    // A stalled ID stage cannot redirect; the hazard unit re-presents the redirect later.
    assign redirect_o = ~stall_i & (z_i | jr_i | j_i);

    always_comb begin
        next_pc_o = pc_plus4_o;
        if (redirect_o) begin
            if (z_i)       next_pc_o = branch_addr_i;
            else if (jr_i) next_pc_o = jr_addr_i;
            else           next_pc_o = jump_addr_i;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage and IF/ID register: PC, fetch FSM (FETCH/HOLD/KILL), stall skid buffer.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Stall,
    input  logic                       Z,
    input  logic [31:0]                BranchAddr,
    input  logic                       J,
    input  logic [31:0]                JumpAddr,
    input  logic                       JR,
    input  logic [31:0]                JrAddr,
    instruction_fetch_if.master        imem,
    output logic [31:0]                Instruction_id,
    output logic [31:0]                PC_id,
    output logic                       Valid_id
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  kill_addr_q, kill_addr_d;
    logic [31:0]  skid_instr_q, skid_instr_d;
    logic [31:0]  skid_pc_q, skid_pc_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic [31:0]  ifid_pc_q, ifid_pc_d;
    logic         ifid_vld_q, ifid_vld_d;
    logic         req_en_q;

    logic         redirect;
    logic         done;
    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;

    pc_select u_pc_select (
        .stall_i       (Stall),
        .z_i           (Z),
        .jr_i          (JR),
        .j_i           (J),
        .branch_addr_i (BranchAddr),
        .jr_addr_i     (JrAddr),
        .jump_addr_i   (JumpAddr),
        .pc_i          (pc_q),
        .redirect_o    (redirect),
        .pc_plus4_o    (pc_plus4),
        .next_pc_o     (next_pc)
    );

    // KILL keeps presenting the abandoned address until the memory finishes it.
    assign imem.Imem_Req  = req_en_q & (state_q != S_HOLD);
    assign imem.Imem_Addr = (state_q == S_KILL) ? kill_addr_q : pc_q;
    assign done           = imem.Imem_Req & imem.Imem_Ready;

    assign Instruction_id = ifid_instr_q;
    assign PC_id          = ifid_pc_q;
    assign Valid_id       = ifid_vld_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_addr_d  = kill_addr_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_vld_d   = ifid_vld_q;

        unique case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    pc_d         = next_pc;
                    ifid_instr_d = NOP_INSTR;
                    ifid_vld_d   = 1'b0;
                    if (imem.Imem_Req & ~imem.Imem_Ready) begin
                        kill_addr_d = pc_q;
                        state_d     = S_KILL;
                    end
                end else if (done & ~Stall) begin
                    pc_d         = next_pc;
                    ifid_instr_d = imem.Imem_Instr;
                    ifid_pc_d    = pc_plus4;
                    ifid_vld_d   = 1'b1;
                end else if (done) begin
                    pc_d         = next_pc;
                    skid_instr_d = imem.Imem_Instr;
                    skid_pc_d    = pc_plus4;
                    state_d      = S_HOLD;
                end else if (~Stall) begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_vld_d   = 1'b0;
                end
            end
            S_HOLD: begin
                if (~Stall) begin
                    state_d = S_FETCH;
                    if (redirect) begin
                        pc_d         = next_pc;
                        ifid_instr_d = NOP_INSTR;
                        ifid_vld_d   = 1'b0;
                    end else begin
                        ifid_instr_d = skid_instr_q;
                        ifid_pc_d    = skid_pc_q;
                        ifid_vld_d   = 1'b1;
                    end
                end
            end
            S_KILL: begin
                if (redirect) pc_d = next_pc;
                if (~Stall) begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_vld_d   = 1'b0;
                end
                if (done) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            kill_addr_q  <= 32'd0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'd0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'd0;
            ifid_vld_q   <= 1'b0;
            req_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_addr_q  <= kill_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_vld_q   <= ifid_vld_d;
            req_en_q     <= 1'b1;
        end
    end

endmodule
